// File: rtl/tthbif_pkg.sv
// Shared HBIF lane definitions: rx training FSM states and the default
// training word used by both the TX pattern generator and the RX lane.
package tthbif_pkg;

    localparam int DEF_PATTERN_LEN = 8;
    localparam logic [DEF_PATTERN_LEN-1:0] DEF_TRAIN_PATTERN = 8'hA5;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_SETTLE = 3'd1,
        RX_SEARCH = 3'd2,
        RX_LOCKED = 3'd3,
        RX_FAIL   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/tthbif_rx_train_fsm.sv
// Tap-sweep training FSM for the HBIF RX lane. Each tap gets one ignored
// check point (sample pipeline refilling after a tap change), then must
// match MATCH_COUNT consecutive check points to lock. Any mismatch moves to
// the next tap; a mismatch on the last tap ends in FAIL.
module tthbif_rx_train_fsm
    import tthbif_pkg::*;
#(
    parameter  int NUM_TAP     = 4,
    parameter  int MATCH_COUNT = 4,
    localparam int TAP_W       = $clog2(NUM_TAP),
    localparam int MCNT_W      = $clog2(MATCH_COUNT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             check_i,
    input  logic             match_i,
    input  logic             start_i,
    input  logic             override_i,
    output logic [TAP_W-1:0] fsm_tap_o,
    output logic             busy_o,
    output logic             locked_o,
    output logic             fail_o,
    output rx_state_t        state_o
);

    rx_state_t         state;
    logic [TAP_W-1:0]  fsm_tap;
    logic [MCNT_W-1:0] mcnt;
    logic              settle_seen;
    logic              eval_check;

    // A check point is scored in SEARCH, or in SETTLE once the first one
    // after a tap change has been skipped.
    assign eval_check = check_i &&
                        ((state == RX_SEARCH) || ((state == RX_SETTLE) && settle_seen));

    // State, tap, match count and registered status flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= RX_IDLE;
            fsm_tap     <= '0;
            mcnt        <= '0;
            settle_seen <= 1'b0;
            busy_o      <= 1'b0;
            locked_o    <= 1'b0;
            fail_o      <= 1'b0;
        end else if (override_i) begin
            state       <= RX_IDLE;
            fsm_tap     <= '0;
            mcnt        <= '0;
            settle_seen <= 1'b0;
            busy_o      <= 1'b0;
            locked_o    <= 1'b0;
            fail_o      <= 1'b0;
        end else if (start_i) begin
            state       <= RX_SETTLE;
            fsm_tap     <= '0;
            mcnt        <= '0;
            settle_seen <= 1'b0;
            busy_o      <= 1'b1;
            locked_o    <= 1'b0;
            fail_o      <= 1'b0;
        end else if ((state == RX_SETTLE) && check_i && !settle_seen) begin
            settle_seen <= 1'b1;
        end else if (eval_check) begin
            settle_seen <= 1'b0;
            if (match_i) begin
                mcnt <= mcnt + MCNT_W'(1);
                if (mcnt == MCNT_W'(MATCH_COUNT - 1)) begin
                    state    <= RX_LOCKED;
                    busy_o   <= 1'b0;
                    locked_o <= 1'b1;
                end else begin
                    state <= RX_SEARCH;
                end
            end else if (fsm_tap != TAP_W'(NUM_TAP - 1)) begin
                fsm_tap <= fsm_tap + TAP_W'(1);
                mcnt    <= '0;
                state   <= RX_SETTLE;
            end else begin
                state  <= RX_FAIL;
                busy_o <= 1'b0;
                fail_o <= 1'b1;
            end
        end
    end

    assign fsm_tap_o = fsm_tap;
    assign state_o   = state;

endmodule

// File: rtl/tthbif_rx_lane.sv
// HBIF RX lane: selectable flop delay line on the serial input, a frame
// shift register and free-running frame counter, and the training FSM that
// picks the tap putting the training word on the local frame boundary.
// state_o is a debug view of the training FSM.
module tthbif_rx_lane
    import tthbif_pkg::*;
#(
    parameter  int                     NUM_TAP       = 4,
    parameter  int                     PATTERN_LEN   = DEF_PATTERN_LEN,
    parameter  logic [PATTERN_LEN-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
    parameter  int                     MATCH_COUNT   = 4,
    localparam int                     TAP_W         = $clog2(NUM_TAP),
    localparam int                     FCNT_W        = $clog2(PATTERN_LEN)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_i,
    input  logic              train_start_i,
    input  logic              tap_override_i,
    input  logic [TAP_W-1:0]  tap_sel_i,
    output logic              rx_o,
    output logic [TAP_W-1:0]  tap_sel_o,
    output logic [FCNT_W-1:0] frame_cnt_o,
    output logic              busy_o,
    output logic              locked_o,
    output logic              fail_o,
    output rx_state_t         state_o
);

    logic [NUM_TAP-1:0]     dly;
    logic [PATTERN_LEN-1:0] sr;
    logic [FCNT_W-1:0]      fcnt;
    logic [TAP_W-1:0]       fsm_tap;
    logic [TAP_W-1:0]       tap;
    logic                   check;
    logic                   match;

    // Manual tap wins over the trained tap; output is a plain flop mux, so
    // tap k gives k+1 cycles of latency.
    assign tap       = tap_override_i ? tap_sel_i : fsm_tap;
    assign tap_sel_o = tap;
    assign rx_o      = dly[tap];

    // Delay line: dly[0] samples the pad, each later flop adds one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) dly <= '0;
        else         dly <= {dly[NUM_TAP-2:0], rx_i};
    end

    // Frame shift register fed from the selected tap, newest bit in LSB.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sr <= '0;
        else         sr <= {sr[PATTERN_LEN-2:0], rx_o};
    end

    // Free-running frame counter defining the local frame boundary.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                fcnt <= '0;
        else if (fcnt == FCNT_W'(PATTERN_LEN - 1))  fcnt <= '0;
        else                                        fcnt <= fcnt + FCNT_W'(1);
    end

    assign frame_cnt_o = fcnt;
    assign check       = (fcnt == FCNT_W'(PATTERN_LEN - 1));
    assign match       = (sr == TRAIN_PATTERN);

    tthbif_rx_train_fsm #(
        .NUM_TAP     (NUM_TAP),
        .MATCH_COUNT (MATCH_COUNT)
    ) u_fsm (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .check_i    (check),
        .match_i    (match),
        .start_i    (train_start_i),
        .override_i (tap_override_i),
        .fsm_tap_o  (fsm_tap),
        .busy_o     (busy_o),
        .locked_o   (locked_o),
        .fail_o     (fail_o),
        .state_o    (state_o)
    );

endmodule

// File: tb/tb_tthbif_rx_lane.sv
// Bench for the HBIF RX lane. A repeating training word is driven with a
// chosen alignment against the frame counter; the expected locked tap comes
// from the delay arithmetic (tap t needs the MSB at frame count (6-t) mod 8).
module tb_tthbif_rx_lane;
    import tthbif_pkg::*;

    localparam int NUM_TAP     = 4;
    localparam int PATTERN_LEN = 8;
    localparam int MATCH_COUNT = 4;
    localparam logic [7:0] PAT = 8'hA5;
    localparam int BOUND = NUM_TAP * (MATCH_COUNT + 1) * PATTERN_LEN + 2 * PATTERN_LEN;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       rx_i = 1'b0;
    logic       train_start_i = 1'b0;
    logic       tap_override_i = 1'b0;
    logic [1:0] tap_sel_i = 2'd0;
    logic       rx_o;
    logic [1:0] tap_sel_o;
    logic [2:0] frame_cnt_o;
    logic       busy_o;
    logic       locked_o;
    logic       fail_o;
    rx_state_t  state_o;

    int vectors = 0;
    int miscompares = 0;
    int n = 0;          // clock edges since reset release
    int rx_mode = 0;    // 0: constant level, 1: repeating training word
    logic rx_level = 1'b0;
    int align = 0;      // frame count at which the word MSB is driven
    int flip_at = -1;   // cycle whose bit is inverted, -1 for none

    tthbif_rx_lane dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .rx_i           (rx_i),
        .train_start_i  (train_start_i),
        .tap_override_i (tap_override_i),
        .tap_sel_i      (tap_sel_i),
        .rx_o           (rx_o),
        .tap_sel_o      (tap_sel_o),
        .frame_cnt_o    (frame_cnt_o),
        .busy_o         (busy_o),
        .locked_o       (locked_o),
        .fail_o         (fail_o),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) n <= 0;
        else         n <= n + 1;
    end

    function automatic logic pat_bit(input int cyc, input int al);
        int pos;
        logic [7:0] p;
        p = PAT;
        pos = (((cyc - al) % 8) + 8) % 8;
        return p[7 - pos];
    endfunction

    // Tap whose latency lines the word up with the frame boundary, or -1.
    function automatic int model_tap(input int al);
        for (int t = 0; t < NUM_TAP; t++)
            if ((((6 - t) % 8) + 8) % 8 == al) return t;
        return -1;
    endfunction

    // One cycle: sample at negedge, check frame counter, drive next inputs.
    task automatic step(input logic start);
        @(negedge clk);
        vectors++;
        if (frame_cnt_o !== 3'(n % 8)) begin
            miscompares++;
            $display("FAIL frame_cnt: got %0d expected %0d", frame_cnt_o, n % 8);
        end
        train_start_i = start;
        if (rx_mode == 1) rx_i = pat_bit(n, align) ^ (n == flip_at);
        else              rx_i = rx_level;
    endtask

    task automatic wait_done(output bit done);
        done = 1'b0;
        for (int i = 0; i < BOUND && !done; i++) begin
            step(1'b0);
            if (locked_o === 1'b1 || fail_o === 1'b1) begin
                done = 1'b1;
            end else begin
                vectors++;
                if (busy_o !== 1'b1) begin
                    miscompares++;
                    $display("FAIL busy_during_training: got %b expected 1", busy_o);
                end
            end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL training_timeout: got no lock/fail within %0d cycles expected done", BOUND);
        end
    endtask

    task automatic run_training(input int al, input bit do_flip);
        int  exp_t;
        bit  exp_lock;
        bit  done;
        int  s;
        int  c1;
        exp_t = model_tap(al);
        exp_lock = (exp_t >= 0);
        if (!exp_lock) exp_t = NUM_TAP - 1;
        rx_mode = 1;
        align = al;
        flip_at = -1;
        repeat (20 + $urandom_range(0, 7)) step(1'b0);
        if (do_flip) begin
            // Corrupt the MSB seen by the third check point after start.
            s = n + 1;
            c1 = s + 1 + (((7 - (s + 1)) % 8) + 8) % 8;
            flip_at = c1 + 16 - 9;
            exp_lock = 1'b0;
            exp_t = NUM_TAP - 1;
        end
        step(1'b1);
        step(1'b0);
        vectors++;
        if (busy_o !== 1'b1 || locked_o !== 1'b0 || fail_o !== 1'b0 || tap_sel_o !== 2'd0) begin
            miscompares++;
            $display("FAIL start_response: got busy=%b locked=%b fail=%b tap=%0d expected 1 0 0 0",
                     busy_o, locked_o, fail_o, tap_sel_o);
        end
        wait_done(done);
        vectors++;
        if (locked_o !== exp_lock || fail_o !== !exp_lock || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL train_result align=%0d: got locked=%b fail=%b busy=%b expected %b %b 0",
                     al, locked_o, fail_o, busy_o, exp_lock, !exp_lock);
        end
        vectors++;
        if (tap_sel_o !== 2'(exp_t)) begin
            miscompares++;
            $display("FAIL train_tap align=%0d: got %0d expected %0d", al, tap_sel_o, exp_t);
        end
        repeat (10) step(1'b0);
        vectors++;
        if (tap_sel_o !== 2'(exp_t) || locked_o !== exp_lock || fail_o !== !exp_lock) begin
            miscompares++;
            $display("FAIL train_hold align=%0d: got tap=%0d locked=%b fail=%b expected %0d %b %b",
                     al, tap_sel_o, locked_o, fail_o, exp_t, exp_lock, !exp_lock);
        end
        flip_at = -1;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        rx_mode = 0;
        rx_level = 1'b1;
        repeat (3) step(1'b1);
        vectors++;
        if ({rx_o, tap_sel_o, frame_cnt_o, busy_o, locked_o, fail_o} !== 9'd0 || state_o !== RX_IDLE) begin
            miscompares++;
            $display("FAIL reset_outputs: got rx=%b tap=%0d fcnt=%0d busy=%b locked=%b fail=%b expected all 0",
                     rx_o, tap_sel_o, frame_cnt_o, busy_o, locked_o, fail_o);
        end
        step(1'b0);
        #2 rst_ni = 1'b1;
        #1;
        vectors++;
        if (frame_cnt_o !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_release_fcnt: got %0d expected 0", frame_cnt_o);
        end
        rx_mode = 1;
        align = 2;
        repeat (24) begin
            step(1'b0);
            vectors++;
            if (busy_o !== 1'b0 || locked_o !== 1'b0 || fail_o !== 1'b0 || state_o !== RX_IDLE || tap_sel_o !== 2'd0) begin
                miscompares++;
                $display("FAIL idle_without_start: got busy=%b locked=%b fail=%b tap=%0d expected 0 0 0 0",
                         busy_o, locked_o, fail_o, tap_sel_o);
            end
        end
    endtask

    task automatic test_lock;
        run_training(4, 1'b0);
    endtask

    task automatic test_fail_sweep;
        run_training(0, 1'b0);
    endtask

    task automatic test_random_align;
        for (int k = 0; k < 6; k++) run_training(int'($urandom_range(0, 7)), 1'b0);
    endtask

    task automatic test_flipped_bit;
        run_training(6, 1'b1);
    endtask

    task automatic test_restart;
        bit seen;
        bit done;
        rx_mode = 1;
        align = 4;
        flip_at = -1;
        repeat (20) step(1'b0);
        step(1'b1);
        seen = 1'b0;
        for (int i = 0; i < BOUND && !seen; i++) begin
            step(1'b0);
            if (state_o === RX_SEARCH && tap_sel_o === 2'd2) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL restart_reach_search: got no SEARCH at tap 2 expected it within %0d cycles", BOUND);
        end
        step(1'b1);
        step(1'b0);
        vectors++;
        if (state_o !== RX_SETTLE || tap_sel_o !== 2'd0 || dut.u_fsm.mcnt !== 3'd0 || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_clear: got state=%0d tap=%0d mcnt=%0d busy=%b expected %0d 0 0 1",
                     state_o, tap_sel_o, dut.u_fsm.mcnt, busy_o, RX_SETTLE);
        end
        wait_done(done);
        vectors++;
        if (locked_o !== 1'b1 || tap_sel_o !== 2'd2) begin
            miscompares++;
            $display("FAIL restart_relock: got locked=%b tap=%0d expected 1 2", locked_o, tap_sel_o);
        end
    endtask

    task automatic test_override;
        tap_override_i = 1'b1;
        tap_sel_i = 2'd3;
        rx_mode = 0;
        rx_level = 1'b0;
        repeat (6) step(1'b0);
        vectors++;
        if (busy_o !== 1'b0 || locked_o !== 1'b0 || fail_o !== 1'b0 || state_o !== RX_IDLE || tap_sel_o !== 2'd3) begin
            miscompares++;
            $display("FAIL override_state: got busy=%b locked=%b fail=%b tap=%0d expected 0 0 0 3",
                     busy_o, locked_o, fail_o, tap_sel_o);
        end
        rx_level = 1'b1;
        step(1'b0);
        rx_level = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step(k == 2);
            vectors++;
            if (rx_o !== (k == 4)) begin
                miscompares++;
                $display("FAIL override_latency k=%0d: got rx_o=%b expected %b", k, rx_o, (k == 4));
            end
            vectors++;
            if (busy_o !== 1'b0 || locked_o !== 1'b0 || fail_o !== 1'b0) begin
                miscompares++;
                $display("FAIL override_start_ignored: got busy=%b locked=%b fail=%b expected 0 0 0",
                         busy_o, locked_o, fail_o);
            end
        end
        tap_override_i = 1'b0;
        repeat (12) step(1'b0);
        vectors++;
        if (busy_o !== 1'b0 || locked_o !== 1'b0 || fail_o !== 1'b0 || state_o !== RX_IDLE) begin
            miscompares++;
            $display("FAIL override_release: got busy=%b locked=%b fail=%b state=%0d expected idle",
                     busy_o, locked_o, fail_o, state_o);
        end
        run_training(3, 1'b0);
    endtask

    task automatic test_reset_midstream;
        rx_mode = 1;
        align = 5;
        repeat (20) step(1'b0);
        step(1'b1);
        repeat (12) step(1'b0);
        vectors++;
        if (busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_before_reset: got %b expected 1", busy_o);
        end
        @(posedge clk);
        #3 rst_ni = 1'b0;
        #1;
        vectors++;
        if ({rx_o, tap_sel_o, frame_cnt_o, busy_o, locked_o, fail_o} !== 9'd0 || state_o !== RX_IDLE) begin
            miscompares++;
            $display("FAIL midstream_reset: got rx=%b tap=%0d fcnt=%0d busy=%b locked=%b fail=%b expected all 0",
                     rx_o, tap_sel_o, frame_cnt_o, busy_o, locked_o, fail_o);
        end
        repeat (3) step(1'b0);
        vectors++;
        if (rx_o !== 1'b0 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: got rx=%b busy=%b expected 0 0", rx_o, busy_o);
        end
        #2 rst_ni = 1'b1;
        #1;
        vectors++;
        if (frame_cnt_o !== 3'd0) begin
            miscompares++;
            $display("FAIL midstream_release_fcnt: got %0d expected 0", frame_cnt_o);
        end
        repeat (20) step(1'b0);
        vectors++;
        if (busy_o !== 1'b0 || locked_o !== 1'b0 || fail_o !== 1'b0 || state_o !== RX_IDLE) begin
            miscompares++;
            $display("FAIL post_reset_idle: got busy=%b locked=%b fail=%b state=%0d expected idle",
                     busy_o, locked_o, fail_o, state_o);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_fail_sweep();
        test_random_align();
        test_flipped_bit();
        test_restart();
        test_override();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tthbif_rx_lane.md
Name: tthbif_rx_lane

Overview:
Receive-side lane of the HBIF link, the counterpart of the TX lane. Samples the incoming serial bit through a selectable flop delay line. A training FSM sweeps the delay taps until a known repeating pattern lands on the lane's local frame boundary, then locks that tap. Manual tap override supports bring-up and characterisation.

Parameters:
NUM_TAP, 4, number of delay-line taps; tap k gives k+1 cycles of input delay
PATTERN_LEN, 8, training word length in bits; also the frame counter modulus
TRAIN_PATTERN, 8'hA5, training word, sent MSB first
MATCH_COUNT, 4, consecutive frame matches required to lock

Ports:
clk_i  input  1  lane clock
rst_ni  input  1  asynchronous active-low reset
rx_i  input  1  serial data from pad
train_start_i  input  1  single-cycle pulse that starts or restarts training
tap_override_i  input  1  when 1, tap comes from tap_sel_i and the FSM is held
tap_sel_i  input  $clog2(NUM_TAP)  manual tap
rx_o  output  1  delayed sample d[tap]
tap_sel_o  output  $clog2(NUM_TAP)  tap in use
frame_cnt_o  output  $clog2(PATTERN_LEN)  free-running frame counter
busy_o  output  1  training in progress
locked_o  output  1  training succeeded
fail_o  output  1  all taps tried without lock

Behaviour:
- Reset: every flop clears to 0; all outputs 0; state IDLE.
- Delay line:
  - d[0] <= rx_i; d[k] <= d[k-1].
  - rx_o = d[tap], a mux of flop outputs, so latency is tap+1 cycles.
  - tap = tap_override_i ? tap_sel_i : fsm_tap. tap_sel_o shows this value.
- Shift register: sr <= {sr[PATTERN_LEN-2:0], rx_o} every cycle.
- Frame counter: fcnt increments every cycle and wraps PATTERN_LEN-1 -> 0.
- Check point: any cycle with fcnt == PATTERN_LEN-1. "Match" means sr == TRAIN_PATTERN at that cycle.
- Alignment: at a check point, sr[7] = rx_i from 9+tap cycles earlier. Tap t therefore matches when the pattern MSB is driven on rx_i while fcnt == (6 - t) mod 8.
- FSM states and transitions:
  - IDLE: busy=0. On train_start_i: fsm_tap=0, mcnt=0, go SETTLE.
  - SETTLE: busy=1. Ignore the first check point. At the second check point, go to SEARCH and evaluate that check immediately.
  - SEARCH: busy=1.
    - Match: mcnt++. If mcnt reaches MATCH_COUNT, go LOCKED.
    - Mismatch with fsm_tap < NUM_TAP-1: fsm_tap++, mcnt=0, go SETTLE.
    - Mismatch with fsm_tap == NUM_TAP-1: go FAIL.
  - LOCKED: locked=1, busy=0. fsm_tap is held.
  - FAIL: fail=1, busy=0. fsm_tap stays at NUM_TAP-1.
- train_start_i in any state without override (including mid-training) restarts at tap 0 and clears locked/fail on the next cycle.
- tap_override_i=1 forces IDLE, clears busy/locked/fail and ignores train_start_i. When override drops, the lane stays in IDLE.
- Training time is bounded by NUM_TAP*(MATCH_COUNT+1)*PATTERN_LEN cycles.

Decomposition:
- Package tthbif_pkg holds:
  - the rx FSM state enum (IDLE, SETTLE, SEARCH, LOCKED, FAIL);
  - the default TRAIN_PATTERN and PATTERN_LEN constants, shared with the TX lane's pattern generator.
- Sub-module tthbif_rx_train_fsm holds the FSM, mcnt and fsm_tap. Inputs: check, match, start, override.
- The top level holds the delay line, sr, fcnt and tap mux.

Test Plan:
- Reset with rst_ni low mid-stream -> all outputs 0 immediately; fcnt=0 one cycle after release; no state change without a start pulse.
- Repeating 8'hA5 with MSB driven at fcnt==4, then train_start_i -> taps 0 and 1 fail, tap 2 locks. Expect tap_sel_o=2 and locked_o=1; busy_o=0 after lock.
- MSB driven at fcnt==0, i.e. tap 6 needed -> all 4 taps swept, then fail_o=1, tap_sel_o=3, locked_o=0.
- Alignment correct for tap 0, with a single flipped bit in the 3rd frame -> tap 0 mismatches, moves to tap 1, and the sweep ends in FAIL.
- train_start_i pulsed while in SEARCH at tap 2 -> fsm_tap returns to 0, state SETTLE, mcnt cleared; the lane relocks at the correct tap.
- tap_override_i=1 with tap_sel_i=3 and a pulse on rx_i -> rx_o rises exactly 4 cycles later; train_start_i ignored; busy/locked/fail all 0.
